// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared types and constants for the two-layer CNN layer
//               scheduler: FSM state encoding, buffer selects, widths and
//               a helper that identifies the RUN states.
// Revision    : 1.0  initial release
// ============================================================================
package cnn_pkg;

  // Scheduler state encoding (explicit 3-bit width)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT1 = 3'd1,
    ST_RUN1  = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_RUN2  = 3'd4,
    ST_DONE  = 3'd5
  } sched_state_e;

  localparam int unsigned C_ADDR_W = 16;
  localparam int unsigned C_SEL_W  = 5;
  localparam int unsigned C_TMO_W  = 20;
  localparam logic [4:0]  C_L1_SEL = 5'd0;
  localparam logic [4:0]  C_L2_SEL = 5'd1;

  // True while one of the layers is actively computing
  function automatic logic is_run(input sched_state_e s);
    return (s == ST_RUN1) || (s == ST_RUN2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sched_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : sched_watchdog
// Description : Per-RUN-state watchdog. The counter is held at zero while
//               clr is high and advances once per enabled cycle. expire is
//               raised on the enabled cycle whose increment reaches the
//               all-ones terminal count.
// Ports       : clk, rst (async, active-high), clr, en -> expire
// Revision    : 1.0  initial release
// ============================================================================
module sched_watchdog #(
  parameter int unsigned TMO_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // Value one below all-ones: the increment from here lands on terminal count
  localparam logic [TMO_W-1:0] C_LAST = ~TMO_W'(1);

  logic [TMO_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + TMO_W'(1);
    end
  end

  assign expire = en && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/cnn_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cnn_layer_scheduler
// Description : Sequences layer1 then layer2 of the CNN datapath once the
//               pixel/weight/bias stores are complete, owns the shared
//               weight/bias read port (buffer selects + read forwarding),
//               and pulses the completion interrupt request.
// Ports       : clk, rst                      clock, async active-high reset
//               start, abort                  controller pulses
//               l1_*_done, l2_*_done          store-done levels
//               l1_calc_done, l2_calc_done    layer completion pulses
//               l1_rd_*, l2_rd_*              per-layer read requests
//               rd_w/rd_b, rd_*_addr          forwarded reads to memories
//               w_sel/b_sel                   buffer selects
//               l1_en/l2_en, irq_set, busy    control / status
//               err_tmo, err_conf             sticky error flags
// Revision    : 1.0  initial release
// ============================================================================
module cnn_layer_scheduler
  import cnn_pkg::*;
#(
  parameter int unsigned        ADDR_W = C_ADDR_W,
  parameter int unsigned        SEL_W  = C_SEL_W,
  parameter logic [SEL_W-1:0]   L1_SEL = SEL_W'(C_L1_SEL),
  parameter logic [SEL_W-1:0]   L2_SEL = SEL_W'(C_L2_SEL),
  parameter int unsigned        TMO_W  = C_TMO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              l1_pix_done,
  input  logic              l1_w_done,
  input  logic              l1_b_done,
  input  logic              l2_w_done,
  input  logic              l2_b_done,
  input  logic              l1_calc_done,
  input  logic              l2_calc_done,
  input  logic              l1_rd_w,
  input  logic              l1_rd_b,
  input  logic [ADDR_W-1:0] l1_rd_w_addr,
  input  logic [ADDR_W-1:0] l1_rd_b_addr,
  input  logic              l2_rd_w,
  input  logic              l2_rd_b,
  input  logic [ADDR_W-1:0] l2_rd_w_addr,
  input  logic [ADDR_W-1:0] l2_rd_b_addr,
  output logic              rd_w,
  output logic              rd_b,
  output logic [ADDR_W-1:0] rd_w_addr,
  output logic [ADDR_W-1:0] rd_b_addr,
  output logic [SEL_W-1:0]  w_sel,
  output logic [SEL_W-1:0]  b_sel,
  output logic              l1_en,
  output logic              l2_en,
  output logic              irq_set,
  output logic              busy,
  output logic              err_tmo,
  output logic              err_conf
);

  sched_state_e r_state;
  sched_state_e w_next;
  logic         w_tmo_hit;
  logic         w_expire;
  logic         w_clear_flags;
  logic         w_conf;

  // Counter is held clear outside RUN, so every RUN entry starts from zero
  sched_watchdog #(
    .TMO_W (TMO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!is_run(r_state)),
    .en     (is_run(r_state)),
    .expire (w_expire)
  );

  // Next-state decode; abort has priority over every other event, and a
  // done pulse on the terminal-count cycle takes the normal transition.
  always_comb begin
    w_next    = r_state;
    w_tmo_hit = 1'b0;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) w_next = ST_WAIT1;
        ST_WAIT1: if (l1_pix_done && l1_w_done && l1_b_done) w_next = ST_RUN1;
        ST_RUN1: begin
          if (l1_calc_done) begin
            w_next = ST_WAIT2;
          end else if (w_expire) begin
            w_next    = ST_IDLE;
            w_tmo_hit = 1'b1;
          end
        end
        ST_WAIT2: if (l2_w_done && l2_b_done) w_next = ST_RUN2;
        ST_RUN2: begin
          if (l2_calc_done) begin
            w_next = ST_DONE;
          end else if (w_expire) begin
            w_next    = ST_IDLE;
            w_tmo_hit = 1'b1;
          end
        end
        ST_DONE:  w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // An accepted start clears the sticky error flags
  assign w_clear_flags = (r_state == ST_IDLE) && start && !abort;

  // Any request from a layer that does not currently own the port
  assign w_conf = ((r_state != ST_RUN1) && (l1_rd_w || l1_rd_b)) ||
                  ((r_state != ST_RUN2) && (l2_rd_w || l2_rd_b));

  // State and registered outputs, all derived from the next state so they
  // change on the same edge the state does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      l1_en    <= 1'b0;
      l2_en    <= 1'b0;
      irq_set  <= 1'b0;
      busy     <= 1'b0;
      w_sel    <= L1_SEL;
      b_sel    <= L1_SEL;
      err_tmo  <= 1'b0;
      err_conf <= 1'b0;
    end else begin
      r_state  <= w_next;
      l1_en    <= (w_next == ST_RUN1);
      l2_en    <= (w_next == ST_RUN2);
      irq_set  <= (w_next == ST_DONE);
      busy     <= (w_next != ST_IDLE);
      w_sel    <= (w_next inside {ST_WAIT2, ST_RUN2, ST_DONE}) ? L2_SEL : L1_SEL;
      b_sel    <= (w_next inside {ST_WAIT2, ST_RUN2, ST_DONE}) ? L2_SEL : L1_SEL;
      err_tmo  <= (w_clear_flags ? 1'b0 : err_tmo) | w_tmo_hit;
      err_conf <= (w_clear_flags ? 1'b0 : err_conf) | w_conf;
    end
  end

  // Zero-latency read forwarding from the layer that owns the port
  always_comb begin
    rd_w      = 1'b0;
    rd_b      = 1'b0;
    rd_w_addr = '0;
    rd_b_addr = '0;
    case (r_state)
      ST_RUN1: begin
        rd_w      = l1_rd_w;
        rd_b      = l1_rd_b;
        rd_w_addr = l1_rd_w_addr;
        rd_b_addr = l1_rd_b_addr;
      end
      ST_RUN2: begin
        rd_w      = l2_rd_w;
        rd_b      = l2_rd_b;
        rd_w_addr = l2_rd_w_addr;
        rd_b_addr = l2_rd_b_addr;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
